// File: rtl/wb_init_sequencer.sv
// Wishbone pipelined-mode initiator that replays a table of register operations
// (write, poll-until-match, fixed wait, end) after a start pulse. It shares the
// bus with the host bridge and brings up the FM generator and the LO PLL with
// no UART host attached.

module wb_init_sequencer #(
  parameter int unsigned TBL_AW    = 4,
  parameter int unsigned TIMEOUT   = 1023,
  parameter int unsigned MAX_POLLS = 255,
  parameter int unsigned POLL_GAP  = 63
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  output logic [TBL_AW-1:0] o_tbl_addr,
  input  logic [95:0]       i_tbl_entry,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [29:0]       o_wb_addr,
  output logic [31:0]       o_wb_data,
  output logic [3:0]        o_wb_sel,
  input  logic              i_wb_stall,
  input  logic              i_wb_ack,
  input  logic [31:0]       i_wb_data,
  input  logic              i_wb_err,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [TBL_AW-1:0] o_err_index
);

  // Counter widths leave headroom so a zero-valued parameter still gets one bit.
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 2);
  localparam int unsigned PollW = $clog2(MAX_POLLS + 2);
  localparam int unsigned GapW  = $clog2(POLL_GAP + 2);

  localparam logic [TmoW-1:0]  TmoLast = TmoW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [PollW-1:0] PollMax = PollW'(MAX_POLLS);
  localparam logic [GapW-1:0]  GapLast = GapW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  localparam logic [1:0] OpEnd   = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpPoll  = 2'b10;
  localparam logic [1:0] OpWait  = 2'b11;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StReq,
    StAck,
    StGap,
    StWait,
    StNext,
    StDone,
    StError
  } state_e;

  state_e            state_q;
  logic [1:0]        op_q;
  logic [31:0]       mask_q;
  logic [31:0]       wait_cnt_q;
  logic [TmoW-1:0]   tmo_cnt_q;
  logic [PollW-1:0]  poll_cnt_q;
  logic [GapW-1:0]   gap_cnt_q;

  // Table entry fields, valid during DECODE.
  logic [1:0]  ent_op;
  logic [29:0] ent_addr;
  logic [31:0] ent_data;
  logic [31:0] ent_mask;

  assign ent_op   = i_tbl_entry[95:94];
  assign ent_addr = i_tbl_entry[93:64];
  assign ent_data = i_tbl_entry[63:32];
  assign ent_mask = i_tbl_entry[31:0];

  // Full-word transfers only.
  assign o_wb_sel = 4'hF;

  logic in_xfer;
  logic accept;
  logic ack_ok;
  logic poll_match;
  logic xfer_abort;
  logic poll_abort;
  logic abort;

  // Bus handshake decode and abort conditions for the current cycle.
  always_comb begin
    in_xfer    = (state_q == StReq) || (state_q == StAck);
    accept     = (state_q == StReq) && !i_wb_stall;
    // An ack is only meaningful once the strobe has been accepted, which
    // includes the accept cycle itself for zero-latency slaves.
    ack_ok     = i_wb_ack && ((state_q == StAck) || accept);
    // o_wb_data still holds the entry's expected value during a poll.
    poll_match = ((i_wb_data ^ o_wb_data) & mask_q) == 32'd0;
    // Error beats a simultaneous ack; timeout only fires if no ack arrives.
    xfer_abort = in_xfer && (i_wb_err || (!ack_ok && (tmo_cnt_q == TmoLast)));
    poll_abort = (state_q == StGap) && (gap_cnt_q == GapLast) && (poll_cnt_q == PollMax);
    abort      = xfer_abort || poll_abort;
  end

  // Sequencer FSM with registered bus and status outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= StIdle;
      op_q        <= OpEnd;
      mask_q      <= '0;
      wait_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      poll_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      o_tbl_addr  <= '0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_addr   <= '0;
      o_wb_data   <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
      o_err_index <= '0;
    end else if (abort) begin
      state_q     <= StError;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_busy      <= 1'b0;
      o_error     <= 1'b1;
      o_err_index <= o_tbl_addr;
    end else begin
      case (state_q)
        StIdle, StDone, StError: begin
          if (i_start) begin
            state_q    <= StFetch;
            o_tbl_addr <= '0;
            o_done     <= 1'b0;
            o_error    <= 1'b0;
            o_busy     <= 1'b1;
          end
        end

        // Table read latency: entry appears one cycle after the index.
        StFetch: state_q <= StDecode;

        StDecode: begin
          op_q       <= ent_op;
          tmo_cnt_q  <= '0;
          poll_cnt_q <= '0;
          gap_cnt_q  <= '0;
          case (ent_op)
            OpEnd: begin
              state_q <= StDone;
              o_done  <= 1'b1;
              o_busy  <= 1'b0;
            end
            OpWait: begin
              wait_cnt_q <= ent_data;
              state_q    <= StWait;
            end
            default: begin
              o_wb_cyc  <= 1'b1;
              o_wb_stb  <= 1'b1;
              o_wb_we   <= (ent_op == OpWrite);
              o_wb_addr <= ent_addr;
              o_wb_data <= ent_data;
              mask_q    <= ent_mask;
              state_q   <= StReq;
            end
          endcase
        end

        StReq, StAck: begin
          tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          if (ack_ok) begin
            // Transaction complete: release the bus before the next entry.
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_we  <= 1'b0;
            if ((op_q == OpWrite) || poll_match) begin
              state_q <= StNext;
            end else begin
              state_q    <= StGap;
              gap_cnt_q  <= '0;
              poll_cnt_q <= poll_cnt_q + PollW'(1);
            end
          end else if (accept) begin
            o_wb_stb <= 1'b0;
            state_q  <= StAck;
          end
        end

        StGap: begin
          if (gap_cnt_q == GapLast) begin
            // Exhaustion is caught by poll_abort; otherwise issue another read.
            o_wb_cyc  <= 1'b1;
            o_wb_stb  <= 1'b1;
            tmo_cnt_q <= '0;
            state_q   <= StReq;
          end else begin
            gap_cnt_q <= gap_cnt_q + GapW'(1);
          end
        end

        // WAIT n holds for n cycles; n of 0 or 1 both take a single cycle.
        StWait: begin
          if (wait_cnt_q <= 32'd1) begin
            state_q <= StNext;
          end else begin
            wait_cnt_q <= wait_cnt_q - 32'd1;
          end
        end

        StNext: begin
          if (&o_tbl_addr) begin
            // Ran off the end of the table: treat as an implicit END.
            state_q <= StDone;
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
          end else begin
            o_tbl_addr <= o_tbl_addr + TBL_AW'(1);
            state_q    <= StFetch;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  // Keep the op encodings referenced for readers; OpPoll shares the bus path.
  logic unused_op_poll;
  assign unused_op_poll = (op_q == OpPoll);

endmodule

// File: tb/tb_wb_init_sequencer.sv
// Directed bench for wb_init_sequencer: a synchronous table ROM, a configurable
// Wishbone slave (stall, registered/zero-latency/no ack, error injection) and a
// scoreboard of expected bus transactions checked at each accepted strobe.

module tb_wb_init_sequencer;

  localparam int unsigned AW   = 4;
  localparam int unsigned TMO  = 15;
  localparam int unsigned MAXP = 3;
  localparam int unsigned GAP  = 5;

  typedef struct packed {
    logic        we;
    logic [29:0] addr;
    logic [31:0] data;
  } txn_t;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic [AW-1:0] o_tbl_addr;
  logic [95:0]   i_tbl_entry;
  logic          o_wb_cyc, o_wb_stb, o_wb_we;
  logic [29:0]   o_wb_addr;
  logic [31:0]   o_wb_data;
  logic [3:0]    o_wb_sel;
  logic          i_wb_stall, i_wb_ack, i_wb_err;
  logic [31:0]   i_wb_data;
  logic          o_busy, o_done, o_error;
  logic [AW-1:0] o_err_index;

  wb_init_sequencer #(
    .TBL_AW   (AW),
    .TIMEOUT  (TMO),
    .MAX_POLLS(MAXP),
    .POLL_GAP (GAP)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .o_tbl_addr (o_tbl_addr),
    .i_tbl_entry(i_tbl_entry),
    .o_wb_cyc   (o_wb_cyc),
    .o_wb_stb   (o_wb_stb),
    .o_wb_we    (o_wb_we),
    .o_wb_addr  (o_wb_addr),
    .o_wb_data  (o_wb_data),
    .o_wb_sel   (o_wb_sel),
    .i_wb_stall (i_wb_stall),
    .i_wb_ack   (i_wb_ack),
    .i_wb_data  (i_wb_data),
    .i_wb_err   (i_wb_err),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_error    (o_error),
    .o_err_index(o_err_index)
  );

  always #5 i_clk = ~i_clk;

  // Table ROM and slave configuration (written only by the stimulus block).
  logic [95:0] tbl [16];
  logic [31:0] rd_vals [8];
  int stall_cfg    = 0;
  int ack_mode     = 0;   // 0 registered ack, 1 never ack, 2 zero-latency ack
  int err_at       = -1;  // relative index of the transaction answered with err
  bit err_with_ack = 1'b0;
  int rd_base      = 0;
  int acc_base     = 0;

  // Slave state (written only by the slave process).
  int         stall_left = 0;
  int         acc_count  = 0;
  int         ack_count  = 0;
  logic       resp_pend  = 1'b0;
  logic       resp_err_q = 1'b0;
  logic       accept_now;
  logic       resp_now;
  logic       is_err;

  always @(posedge i_clk) i_tbl_entry <= tbl[o_tbl_addr];

  always_comb begin
    i_wb_stall = o_wb_stb && (stall_left != 0);
    accept_now = o_wb_cyc && o_wb_stb && !i_wb_stall;
    resp_now   = (ack_mode == 0) ? resp_pend : (ack_mode == 2) ? accept_now : 1'b0;
    is_err     = (ack_mode == 0) ? resp_err_q : ((acc_count - acc_base) == err_at);
    i_wb_err   = resp_now && is_err;
    i_wb_ack   = resp_now && (!is_err || err_with_ack);
    i_wb_data  = rd_vals[(ack_count - rd_base) & 7];
  end

  always @(posedge i_clk) begin
    if (!o_wb_cyc) stall_left <= stall_cfg;
    else if (o_wb_stb && stall_left != 0) stall_left <= stall_left - 1;
    resp_pend  <= (ack_mode == 0) && accept_now;
    resp_err_q <= (acc_count - acc_base) == err_at;
    if (accept_now) acc_count <= acc_count + 1;
    if (i_wb_ack) ack_count <= ack_count + 1;
  end

  // Scoreboard and observation counters.
  txn_t        exp_q [$];
  int          total = 0;
  int          bad = 0;
  int          stb_cycles, cyc_cycles, ack_cycles, sel_bad, unstable;
  logic        prev_stb = 1'b0;
  logic [29:0] prev_addr;
  logic [31:0] prev_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    txn_t t;
    @(negedge i_clk);
    if (o_wb_stb) stb_cycles++;
    if (o_wb_cyc) cyc_cycles++;
    if (i_wb_ack) ack_cycles++;
    if (o_wb_sel !== 4'hF) sel_bad++;
    if (o_wb_stb && prev_stb && (o_wb_addr !== prev_addr || o_wb_data !== prev_data)) unstable++;
    prev_stb  = o_wb_stb;
    prev_addr = o_wb_addr;
    prev_data = o_wb_data;
    if (accept_now) begin
      check("txn_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        t = exp_q.pop_front();
        check("txn_we", 64'(o_wb_we), 64'(t.we));
        check("txn_addr", 64'(o_wb_addr), 64'(t.addr));
        if (t.we) check("txn_data", 64'(o_wb_data), 64'(t.data));
      end
    end
  endtask

  function automatic logic [95:0] ent(input logic [1:0] op, input logic [29:0] a,
                                      input logic [31:0] d, input logic [31:0] m);
    return {op, a, d, m};
  endfunction

  function automatic txn_t mk(input logic we, input logic [29:0] a, input logic [31:0] d);
    txn_t t;
    t.we   = we;
    t.addr = a;
    t.data = d;
    return t;
  endfunction

  task automatic clear_table();
    for (int i = 0; i < 16; i++) tbl[i] = '0;
    for (int i = 0; i < 8; i++) rd_vals[i] = '0;
  endtask

  task automatic clear_stats();
    stb_cycles = 0;
    cyc_cycles = 0;
    ack_cycles = 0;
    unstable   = 0;
    rd_base    = ack_count;
    acc_base   = acc_count;
  endtask

  // Pulse start, then confirm the restart cleared sticky status.
  task automatic start(input string tag);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check({tag, "_busy_after_start"}, 64'(o_busy), 64'd1);
    check({tag, "_status_cleared"}, 64'({o_done, o_error}), 64'd0);
  endtask

  task automatic run(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (o_busy && n < budget);
  endtask

  int n;
  int k;

  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    sel_bad = 0;
    clear_table();
    clear_stats();
    repeat (3) tick();

    // Reset state.
    check("rst_bus", 64'({o_wb_cyc, o_wb_stb, o_wb_we}), 64'd0);
    check("rst_addr_data", 64'({o_wb_addr, o_wb_data}), 64'd0);
    check("rst_sel", 64'(o_wb_sel), 64'hF);
    check("rst_tbl_addr", 64'(o_tbl_addr), 64'd0);
    check("rst_status", 64'({o_busy, o_done, o_error, o_err_index}), 64'd0);
    i_reset = 1'b0;
    tick();

    // Single write, zero-stall registered-ack slave.
    clear_table();
    tbl[0] = ent(2'b01, 30'h2081, 32'hDEADBEEF, 32'h0);
    clear_stats();
    exp_q.push_back(mk(1'b1, 30'h2081, 32'hDEADBEEF));
    start("wr");
    run(50, n);
    check("wr_cycles", 64'(n), 64'd7);
    check("wr_done", 64'({o_done, o_error}), 64'b10);
    check("wr_stb_cycles", 64'(stb_cycles), 64'd1);
    check("wr_acks", 64'(ack_cycles), 64'd1);
    check("wr_q_empty", 64'(exp_q.size()), 64'd0);

    // Write held by three stall cycles.
    clear_table();
    tbl[0] = ent(2'b01, 30'h2082, 32'h12345678, 32'h0);
    stall_cfg = 3;
    clear_stats();
    exp_q.push_back(mk(1'b1, 30'h2082, 32'h12345678));
    start("stall");
    run(50, n);
    stall_cfg = 0;
    check("stall_cycles", 64'(n), 64'd10);
    check("stall_stb_cycles", 64'(stb_cycles), 64'd4);
    check("stall_stable", 64'(unstable), 64'd0);
    check("stall_acks", 64'(ack_cycles), 64'd1);
    check("stall_done", 64'(o_done), 64'd1);

    // Poll PLL lock: reads 0, 0, 1.
    clear_table();
    tbl[0] = ent(2'b10, 30'h20C1, 32'h1, 32'h1);
    clear_stats();
    rd_vals[0] = 32'h0;
    rd_vals[1] = 32'hFFFF_FFFE;
    rd_vals[2] = 32'h0000_0003;
    repeat (3) exp_q.push_back(mk(1'b0, 30'h20C1, 32'h0));
    start("poll");
    run(200, n);
    check("poll_cycles", 64'(n), 64'(7 + 2 * (2 + GAP)));
    check("poll_cyc_cycles", 64'(cyc_cycles), 64'd6);
    check("poll_done", 64'({o_done, o_error}), 64'b10);
    check("poll_q_empty", 64'(exp_q.size()), 64'd0);

    // Poll that never matches exhausts its attempts at entry 1.
    clear_table();
    tbl[0] = ent(2'b01, 30'h2080, 32'h5, 32'h0);
    tbl[1] = ent(2'b10, 30'h20C1, 32'h1, 32'h1);
    clear_stats();
    exp_q.push_back(mk(1'b1, 30'h2080, 32'h5));
    repeat (MAXP) exp_q.push_back(mk(1'b0, 30'h20C1, 32'h0));
    start("exhaust");
    run(300, n);
    check("exhaust_status", 64'({o_done, o_error}), 64'b01);
    check("exhaust_index", 64'(o_err_index), 64'd1);
    check("exhaust_cyc", 64'(o_wb_cyc), 64'd0);
    check("exhaust_stb_cycles", 64'(stb_cycles), 64'(1 + MAXP));
    check("exhaust_q_empty", 64'(exp_q.size()), 64'd0);

    // Slave never acks: abort after TIMEOUT cycles of bus ownership.
    clear_table();
    tbl[0] = ent(2'b01, 30'h2083, 32'hCAFE, 32'h0);
    ack_mode = 1;
    clear_stats();
    exp_q.push_back(mk(1'b1, 30'h2083, 32'hCAFE));
    start("tmo");
    run(100, n);
    ack_mode = 0;
    check("tmo_cyc_cycles", 64'(cyc_cycles), 64'(TMO));
    check("tmo_status", 64'({o_done, o_error, o_err_index}), 64'({2'b01, 4'd0}));

    // Bus error (with a simultaneous ack) on entry 2.
    clear_table();
    tbl[0] = ent(2'b01, 30'h2090, 32'h10, 32'h0);
    tbl[1] = ent(2'b01, 30'h2091, 32'h11, 32'h0);
    tbl[2] = ent(2'b01, 30'h2092, 32'h12, 32'h0);
    tbl[3] = ent(2'b01, 30'h2093, 32'h13, 32'h0);
    clear_stats();
    err_at = 2;
    err_with_ack = 1'b1;
    exp_q.push_back(mk(1'b1, 30'h2090, 32'h10));
    exp_q.push_back(mk(1'b1, 30'h2091, 32'h11));
    exp_q.push_back(mk(1'b1, 30'h2092, 32'h12));
    start("err");
    run(100, n);
    err_at = -1;
    err_with_ack = 1'b0;
    check("err_status", 64'({o_done, o_error}), 64'b01);
    check("err_index", 64'(o_err_index), 64'd2);
    check("err_q_empty", 64'(exp_q.size()), 64'd0);

    // Zero-latency slave: ack in the accept cycle, write then matching poll.
    clear_table();
    tbl[0] = ent(2'b01, 30'h2085, 32'hA5A5A5A5, 32'h0);
    tbl[1] = ent(2'b10, 30'h20C2, 32'h10, 32'h10);
    ack_mode = 2;
    clear_stats();
    rd_vals[1] = 32'h30;
    exp_q.push_back(mk(1'b1, 30'h2085, 32'hA5A5A5A5));
    exp_q.push_back(mk(1'b0, 30'h20C2, 32'h0));
    start("zl");
    run(60, n);
    ack_mode = 0;
    check("zl_cycles", 64'(n), 64'd10);
    check("zl_acks", 64'(ack_cycles), 64'd2);
    check("zl_done", 64'({o_done, o_error}), 64'b10);

    // WAIT 10 then WRITE; a start pulse mid-wait must be ignored.
    clear_table();
    tbl[0] = ent(2'b11, 30'h0, 32'd10, 32'h0);
    tbl[1] = ent(2'b01, 30'h2086, 32'h77, 32'h0);
    clear_stats();
    exp_q.push_back(mk(1'b1, 30'h2086, 32'h77));
    start("wait");
    k = 0;
    do begin
      i_start = (k == 5);
      tick();
      k++;
    end while (!o_wb_stb && k < 100);
    i_start = 1'b0;
    check("wait10_stb_latency", 64'(k), 64'd15);
    run(50, n);
    check("wait10_done", 64'({o_done, o_error}), 64'b10);

    // WAIT 0 passes in a single cycle.
    clear_table();
    tbl[0] = ent(2'b11, 30'h0, 32'd0, 32'h0);
    tbl[1] = ent(2'b01, 30'h2087, 32'h88, 32'h0);
    clear_stats();
    exp_q.push_back(mk(1'b1, 30'h2087, 32'h88));
    start("wait0");
    k = 0;
    do begin
      tick();
      k++;
    end while (!o_wb_stb && k < 100);
    check("wait0_stb_latency", 64'(k), 64'd6);
    run(50, n);
    check("wait0_done", 64'(o_done), 64'd1);

    // Full table with no END: index wraps into an implicit END.
    clear_table();
    for (int i = 0; i < 16; i++) tbl[i] = ent(2'b11, 30'h0, 32'd0, 32'h0);
    clear_stats();
    start("wrap");
    run(200, n);
    check("wrap_cycles", 64'(n), 64'd64);
    check("wrap_status", 64'({o_done, o_error}), 64'b10);

    // Asynchronous reset while a stalled request is on the bus.
    clear_table();
    tbl[0] = ent(2'b01, 30'h2088, 32'h99, 32'h0);
    stall_cfg = 30;
    clear_stats();
    start("arst");
    k = 0;
    while (!o_wb_stb && k < 20) begin
      tick();
      k++;
    end
    check("arst_stb_seen", 64'(o_wb_stb), 64'd1);
    #2 i_reset = 1'b1;
    #1;
    check("arst_bus_drop", 64'({o_wb_cyc, o_wb_stb}), 64'd0);
    check("arst_busy", 64'(o_busy), 64'd0);
    tick();
    i_reset = 1'b0;
    stall_cfg = 0;
    tick();
    check("arst_idle", 64'({o_busy, o_done, o_error, o_tbl_addr}), 64'd0);

    check("sel_always_f", 64'(sel_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
